// File: rtl/debug_oci_arbiter.sv
// -----------------------------------------------------------------------------
// debug_oci_arbiter
//
// Purpose:
//   Arbitrates two single-outstanding debug requesters (JTAG side and Avalon
//   side) onto one OCI register port.
//   - Round-robin: on a tie the side not granted last wins. After reset JTAG
//     wins the first tie.
//   - One OCI transaction is in flight at a time: IDLE -> ISSUE -> DONE.
//   - Every output is a flop.
//   - Minimum latency: request sampled in cycle N, strobe in N+1, ack in N+3.
//
// Optional feature (macro DEBUG_ARB_TIMEOUT_EN):
//   A 10-bit counter counts stalled ISSUE cycles. When it reaches TIMEOUT the
//   access is aborted and acked with err=1 and rdata=0.
//   Without the macro the counter does not exist, err is tied 0 and ISSUE
//   waits for as long as waitrequest stays high.
//
// Parameters:
//   ADDR_W   OCI register address width
//   TIMEOUT  stall cycles before abort (1..1023, timeout build only)
//
// Ports:
//   clk, reset_n                system clock, asynchronous active-low reset
//   jtag_* / av_*               requester side:
//                                 req, wr, addr, wdata in
//                                 ack, rdata, err out (valid with ack)
//   oci_read, oci_write         OCI strobes, never asserted together
//   oci_addr, oci_wdata         OCI address and write data
//   oci_rdata, oci_waitrequest  OCI read data and stall
// -----------------------------------------------------------------------------
module debug_oci_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              jtag_req,
   input  logic              jtag_wr,
   input  logic [ADDR_W-1:0] jtag_addr,
   input  logic [31:0]       jtag_wdata,
   output logic              jtag_ack,
   output logic [31:0]       jtag_rdata,
   output logic              jtag_err,
   input  logic              av_req,
   input  logic              av_wr,
   input  logic [ADDR_W-1:0] av_addr,
   input  logic [31:0]       av_wdata,
   output logic              av_ack,
   output logic [31:0]       av_rdata,
   output logic              av_err,
   output logic              oci_read,
   output logic              oci_write,
   output logic [ADDR_W-1:0] oci_addr,
   output logic [31:0]       oci_wdata,
   input  logic [31:0]       oci_rdata,
   input  logic              oci_waitrequest
);

   if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_timeout_range
      $error("debug_oci_arbiter: TIMEOUT must be within 1..1023");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            r_state,      w_state_next;
   logic              r_grant,      w_grant_next;      // last/current grant, 1 = Avalon
   logic              r_read,       w_read_next;
   logic              r_write,      w_write_next;
   logic [ADDR_W-1:0] r_addr,       w_addr_next;
   logic [31:0]       r_wdata,      w_wdata_next;
   logic [31:0]       r_cap,        w_cap_next;        // read data waiting for DONE
   logic              r_jtag_ack,   w_jtag_ack_next;
   logic              r_av_ack,     w_av_ack_next;
   logic [31:0]       r_jtag_rdata, w_jtag_rdata_next;
   logic [31:0]       r_av_rdata,   w_av_rdata_next;
   logic              w_jtag_req;
   logic              w_av_req;
   logic              w_pick_av;

`ifdef DEBUG_ARB_TIMEOUT_EN
   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
   logic [9:0]        r_tmo_cnt,    w_tmo_cnt_next;
   logic              r_abort,      w_abort_next;
   logic              r_jtag_err,   w_jtag_err_next;
   logic              r_av_err,     w_av_err_next;
`endif

   // A level request is still high during the cycle its own ack is shown.
   // Masking it there means only a request still held one cycle later
   // starts a new access.
   assign w_jtag_req = jtag_req & ~r_jtag_ack;
   assign w_av_req   = av_req   & ~r_av_ack;

   // Avalon wins when it is the only requester, or on a tie when JTAG was
   // the side granted last.
   assign w_pick_av  = w_av_req & (~w_jtag_req | ~r_grant);

   always_comb begin
      w_state_next      = r_state;
      w_grant_next      = r_grant;
      w_read_next       = r_read;
      w_write_next      = r_write;
      w_addr_next       = r_addr;
      w_wdata_next      = r_wdata;
      w_cap_next        = r_cap;
      w_jtag_ack_next   = 1'b0;
      w_av_ack_next     = 1'b0;
      w_jtag_rdata_next = r_jtag_rdata;
      w_av_rdata_next   = r_av_rdata;
`ifdef DEBUG_ARB_TIMEOUT_EN
      w_tmo_cnt_next    = r_tmo_cnt;
      w_abort_next      = r_abort;
      w_jtag_err_next   = r_jtag_err;
      w_av_err_next     = r_av_err;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_jtag_req | w_av_req) begin
               w_grant_next = w_pick_av;
               w_read_next  = w_pick_av ? ~av_wr : ~jtag_wr;
               w_write_next = w_pick_av ?  av_wr :  jtag_wr;
               w_addr_next  = w_pick_av ? av_addr  : jtag_addr;
               w_wdata_next = w_pick_av ? av_wdata : jtag_wdata;
`ifdef DEBUG_ARB_TIMEOUT_EN
               w_tmo_cnt_next = '0;
               w_abort_next   = 1'b0;
`endif
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!oci_waitrequest) begin
               w_read_next  = 1'b0;
               w_write_next = 1'b0;
               // Writes return zero read data.
               w_cap_next   = r_read ? oci_rdata : 32'h0;
               w_state_next = ST_DONE;
            end
`ifdef DEBUG_ARB_TIMEOUT_EN
            else if (r_tmo_cnt == TMO_LAST) begin
               // This stalled cycle is the TIMEOUT-th one: give up.
               w_read_next  = 1'b0;
               w_write_next = 1'b0;
               w_cap_next   = 32'h0;
               w_abort_next = 1'b1;
               w_state_next = ST_DONE;
            end else begin
               w_tmo_cnt_next = r_tmo_cnt + 10'd1;
            end
`endif
         end
         ST_DONE: begin
            // Only the granted side's ack, rdata and err change here.
            if (r_grant) begin
               w_av_ack_next   = 1'b1;
               w_av_rdata_next = r_cap;
`ifdef DEBUG_ARB_TIMEOUT_EN
               w_av_err_next   = r_abort;
`endif
            end else begin
               w_jtag_ack_next   = 1'b1;
               w_jtag_rdata_next = r_cap;
`ifdef DEBUG_ARB_TIMEOUT_EN
               w_jtag_err_next   = r_abort;
`endif
            end
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b1;      // as if Avalon went last, so JTAG wins the first tie
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cap        <= '0;
         r_jtag_ack   <= 1'b0;
         r_av_ack     <= 1'b0;
         r_jtag_rdata <= '0;
         r_av_rdata   <= '0;
`ifdef DEBUG_ARB_TIMEOUT_EN
         r_tmo_cnt    <= '0;
         r_abort      <= 1'b0;
         r_jtag_err   <= 1'b0;
         r_av_err     <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_read       <= w_read_next;
         r_write      <= w_write_next;
         r_addr       <= w_addr_next;
         r_wdata      <= w_wdata_next;
         r_cap        <= w_cap_next;
         r_jtag_ack   <= w_jtag_ack_next;
         r_av_ack     <= w_av_ack_next;
         r_jtag_rdata <= w_jtag_rdata_next;
         r_av_rdata   <= w_av_rdata_next;
`ifdef DEBUG_ARB_TIMEOUT_EN
         r_tmo_cnt    <= w_tmo_cnt_next;
         r_abort      <= w_abort_next;
         r_jtag_err   <= w_jtag_err_next;
         r_av_err     <= w_av_err_next;
`endif
      end
   end

   assign oci_read   = r_read;
   assign oci_write  = r_write;
   assign oci_addr   = r_addr;
   assign oci_wdata  = r_wdata;
   assign jtag_ack   = r_jtag_ack;
   assign av_ack     = r_av_ack;
   assign jtag_rdata = r_jtag_rdata;
   assign av_rdata   = r_av_rdata;
`ifdef DEBUG_ARB_TIMEOUT_EN
   assign jtag_err   = r_jtag_err;
   assign av_err     = r_av_err;
`else
   assign jtag_err   = 1'b0;
   assign av_err     = 1'b0;
`endif

endmodule

// File: tb/tb_debug_oci_arbiter.sv
// -----------------------------------------------------------------------------
// tb_debug_oci_arbiter
//
// Purpose:
//   Scoreboard bench for debug_oci_arbiter.
//   - Requester agents (index 0 = JTAG, 1 = Avalon) hold a level request
//     until they see its ack.
//   - A small OCI slave answers with a stall count chosen per test.
//   - Expected OCI accesses and acks are queued when stimulus is queued, and
//     popped when the DUT shows a strobe or an ack.
//   - The timeout case is built only with DEBUG_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debug_oci_arbiter;

   localparam int ADDR_W = 8;
   localparam int TMO    = 8;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } item_t;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic        chk_rdata;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic             clk       = 1'b0;
   logic             reset_n   = 1'b0;
   logic [1:0]       req       = '0;
   logic [1:0]       wr        = '0;
   logic [1:0][7:0]  addr      = '0;
   logic [1:0][31:0] wdata     = '0;
   logic [1:0]       ack;
   logic [1:0]       err;
   logic [1:0][31:0] rdata;
   logic             oci_read;
   logic             oci_write;
   logic [7:0]       oci_addr;
   logic [31:0]      oci_wdata;
   logic [31:0]      oci_rdata = '0;
   logic             wreq      = 1'b0;

   item_t stim_q0[$];
   item_t stim_q1[$];
   exp_t  exp_q0[$];
   exp_t  exp_q1[$];
   item_t oci_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_cfg = 0;
   logic [1:0]  busy = '0;
   int          ack_cnt [2]      = '{0, 0};
   int          last_req_cyc [2] = '{0, 0};
   int          last_ack_cyc [2] = '{0, 0};
   logic [31:0] held [2]         = '{32'h0, 32'h0};
   logic        held_ok [2]      = '{1'b1, 1'b1};
   int          strobe_start = 0;
   int          strobe_len = 0;
   int          strobe_drop = 0;
   logic        prev_strobe = 1'b0;
   logic [1:0]  prev_ack = '0;
   logic [41:0] lat = '0;

   debug_oci_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .jtag_req        (req[0]),
      .jtag_wr         (wr[0]),
      .jtag_addr       (addr[0]),
      .jtag_wdata      (wdata[0]),
      .jtag_ack        (ack[0]),
      .jtag_rdata      (rdata[0]),
      .jtag_err        (err[0]),
      .av_req          (req[1]),
      .av_wr           (wr[1]),
      .av_addr         (addr[1]),
      .av_wdata        (wdata[1]),
      .av_ack          (ack[1]),
      .av_rdata        (rdata[1]),
      .av_err          (err[1]),
      .oci_read        (oci_read),
      .oci_write       (oci_write),
      .oci_addr        (oci_addr),
      .oci_wdata       (oci_wdata),
      .oci_rdata       (oci_rdata),
      .oci_waitrequest (wreq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Slave register contents.
   function automatic logic [31:0] slave_data(input logic [7:0] a);
      if (a == 8'h10) return 32'hCAFE_F00D;
      return {a, a ^ 8'h5A, ~a, 8'h3C};
   endfunction

   // Queue one access in grant order.
   task automatic push(input int s, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic e);
      item_t it;
      exp_t  ex;
      it.wr = w; it.addr = a; it.wdata = d;
      ex.wr = w; ex.addr = a; ex.err = e;
      ex.chk_rdata = e | ~w;
      ex.rdata = (e | w) ? 32'h0 : slave_data(a);
      if (s == 0) begin
         stim_q0.push_back(it);
         exp_q0.push_back(ex);
      end else begin
         stim_q1.push_back(it);
         exp_q1.push_back(ex);
      end
      oci_q.push_back(it);
   endtask

   function automatic int pending();
      return stim_q0.size() + stim_q1.size() + exp_q0.size() + exp_q1.size()
           + oci_q.size() + int'(busy[0]) + int'(busy[1]);
   endfunction

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (n < budget && pending() != 0) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_drain"}, pending(), 0);
   endtask

   task automatic flush();
      stim_q0.delete(); stim_q1.delete();
      exp_q0.delete();  exp_q1.delete();
      oci_q.delete();
      busy = '0;
      req  = '0;
      held[0] = 32'h0; held[1] = 32'h0;
      held_ok[0] = 1'b1; held_ok[1] = 1'b1;
   endtask

   // Requester: keeps its request high until it sees the ack, then either
   // loads the next queued access or drops the request.
   task automatic agent(input int s);
      item_t it;
      logic  have;
      forever begin
         @(negedge clk);
         if (busy[s] && ack[s]) busy[s] = 1'b0;
         if (!busy[s]) begin
            have = 1'b0;
            if (s == 0 && stim_q0.size() > 0) begin it = stim_q0.pop_front(); have = 1'b1; end
            if (s == 1 && stim_q1.size() > 0) begin it = stim_q1.pop_front(); have = 1'b1; end
            if (have) begin
               req[s]   = 1'b1;
               wr[s]    = it.wr;
               addr[s]  = it.addr;
               wdata[s] = it.wdata;
               busy[s]  = 1'b1;
               last_req_cyc[s] = cyc;
            end else begin
               req[s] = 1'b0;
            end
         end
      end
   endtask

   // OCI slave: stalls each access for stall_cfg cycles.
   task automatic slave();
      int   stall_left;
      logic active;
      stall_left = 0;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (oci_read === 1'b1 || oci_write === 1'b1) begin
            if (!active) begin
               active = 1'b1;
               stall_left = stall_cfg;
            end
            if (stall_left > 0) begin
               wreq = 1'b1;
               stall_left--;
            end else begin
               wreq = 1'b0;
            end
            oci_rdata = oci_read ? slave_data(oci_addr) : 32'h0BAD_0BAD;
         end else begin
            active = 1'b0;
            wreq = 1'b0;
            oci_rdata = 32'hFFFF_FFFF;
         end
      end
   endtask

   // Monitor: OCI side and ack side.
   always @(negedge clk) begin : mon
      logic  strobe;
      item_t it;
      exp_t  ex;
      logic  have;
      int    o;
      strobe = (oci_read === 1'b1) || (oci_write === 1'b1);
      if (strobe && !prev_strobe) begin
         strobe_start = cyc;
         check("oci_excl", oci_read & oci_write, 1'b0);
         check("oci_expected", oci_q.size() > 0, 1'b1);
         if (oci_q.size() > 0) begin
            it = oci_q.pop_front();
            check("oci_wr", oci_write, it.wr);
            check("oci_addr", oci_addr, it.addr);
            check("oci_wdata", oci_wdata, it.wdata);
         end
         lat = {oci_read, oci_write, oci_addr, oci_wdata};
      end else if (strobe) begin
         check("oci_stable", {oci_read, oci_write, oci_addr, oci_wdata}, lat);
      end
      if (!strobe && prev_strobe) begin
         strobe_len  = cyc - strobe_start;
         strobe_drop = cyc;
      end
      prev_strobe = strobe;

      for (int s = 0; s < 2; s++) begin
         if (prev_ack[s]) check($sformatf("ack_one_cycle_%0d", s), ack[s], 1'b0);
         if (ack[s] === 1'b1) begin
            ack_cnt[s]++;
            last_ack_cyc[s] = cyc;
            have = 1'b0;
            if (s == 0 && exp_q0.size() > 0) begin ex = exp_q0.pop_front(); have = 1'b1; end
            if (s == 1 && exp_q1.size() > 0) begin ex = exp_q1.pop_front(); have = 1'b1; end
            check($sformatf("ack_expected_%0d", s), have, 1'b1);
            if (have) begin
               if (ex.chk_rdata) check($sformatf("rdata_%0d", s), rdata[s], ex.rdata);
               check($sformatf("err_%0d", s), err[s], ex.err);
               held[s]    = ex.rdata;
               held_ok[s] = ex.chk_rdata;
               $display("txn %s wr=%0d addr=0x%02h rdata=0x%08h err=%0d cycle=%0d",
                        (s == 0) ? "JTAG" : "AV  ", ex.wr, ex.addr, rdata[s], err[s], cyc);
            end
            o = 1 - s;
            check($sformatf("other_ack_low_%0d", o), ack[o], 1'b0);
            if (held_ok[o]) check($sformatf("other_rdata_hold_%0d", o), rdata[o], held[o]);
         end
         prev_ack[s] = (ack[s] === 1'b1);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      int saved;
      fork
         agent(0);
         agent(1);
         slave();
      join_none

      // Reset values
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_strobes", {oci_read, oci_write}, 2'b00);
      check("rst_acks", ack, 2'b00);
      check("rst_errs", err, 2'b00);
      check("rst_jtag_rdata", rdata[0], 32'h0);
      check("rst_av_rdata", rdata[1], 32'h0);
      check("rst_oci_addr_wdata", {oci_addr, oci_wdata}, 40'h0);
      reset_n = 1'b1;

      // Tie straight after reset: JTAG first, then Avalon exactly once
      @(posedge clk);
      push(0, 1'b0, 8'h20, 32'h0, 1'b0);
      push(1, 1'b0, 8'h30, 32'h0, 1'b0);
      wait_idle("tie", 50);
      check("tie_jtag_acks", ack_cnt[0], 1);
      check("tie_av_acks", ack_cnt[1], 1);

      // Minimum-latency JTAG read of 0x10
      @(posedge clk);
      push(0, 1'b0, 8'h10, 32'h0, 1'b0);
      wait_idle("lat", 50);
      check("lat_strobe", strobe_start - last_req_cyc[0], 1);
      check("lat_ack", last_ack_cyc[0] - last_req_cyc[0], 3);

      // Avalon write stalled for 5 cycles
      stall_cfg = 5;
      @(posedge clk);
      push(1, 1'b1, 8'h04, 32'h1234_5678, 1'b0);
      wait_idle("stall", 80);
      check("stall_strobe_len", strobe_len, 6);
      check("stall_ack_after_drop", last_ack_cyc[1] - strobe_drop, 1);

      // Both sides hold requests for six accesses: J,A,J,A,J,A
      stall_cfg = 1;
      saved = ack_cnt[0] + ack_cnt[1];
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         push(0, k[0], 8'h40 + 8'(k), 32'hA000_0000 + k, 1'b0);
         push(1, ~k[0], 8'h50 + 8'(k), 32'hB000_0000 + k, 1'b0);
      end
      wait_idle("alt", 200);
      check("alt_acks", ack_cnt[0] + ack_cnt[1], saved + 6);

      // Lone Avalon request right after an Avalon grant
      stall_cfg = 0;
      @(posedge clk);
      push(1, 1'b0, 8'h60, 32'h0, 1'b0);
      wait_idle("single_av", 50);

`ifdef DEBUG_ARB_TIMEOUT_EN
      // waitrequest stuck high: abort after TMO stalled cycles
      stall_cfg = 1000;
      @(posedge clk);
      push(0, 1'b0, 8'h70, 32'h0, 1'b1);
      wait_idle("tmo", 100);
      check("tmo_strobe_len", strobe_len, TMO);
      stall_cfg = 0;
`else
      // A long stall still completes normally
      stall_cfg = 40;
      @(posedge clk);
      push(0, 1'b0, 8'h70, 32'h0, 1'b0);
      wait_idle("long_stall", 100);
      check("long_stall_len", strobe_len, 41);
      stall_cfg = 0;
`endif

      // Reset during ISSUE
      stall_cfg = 20;
      @(posedge clk);
      push(0, 1'b0, 8'h44, 32'h0, 1'b0);
      n = 0;
      while (oci_read !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_strobe_seen", oci_read, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_async_strobes", {oci_read, oci_write}, 2'b00);
      flush();
      saved = ack_cnt[0] + ack_cnt[1];
      repeat (3) @(negedge clk);
      check("rst_mid_jtag_rdata", rdata[0], 32'h0);
      check("rst_mid_av_rdata", rdata[1], 32'h0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_no_ack", ack_cnt[0] + ack_cnt[1], saved);

      // Normal JTAG read after the mid-access reset
      stall_cfg = 0;
      @(posedge clk);
      push(0, 1'b0, 8'h10, 32'h0, 1'b0);
      wait_idle("post_rst", 50);
      check("post_rst_acks", ack_cnt[0] + ack_cnt[1], saved + 1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_oci_arbiter.md
DEBUG_OCI_ARBITER -- requirements
Module: debug_oci_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: OCI register address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum waitrequest cycles before abort, range 1..1023, used only with DEBUG_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk, in, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, in, 1: asynchronous active-low reset.
REQ-005 SHALL have ports jtag_req / av_req, in, 1 each: level request from the JTAG-side and Avalon-side requesters.
REQ-006 SHALL have ports jtag_wr / av_wr, in, 1 each: 1=write, 0=read.
REQ-007 SHALL have ports jtag_addr / av_addr, in, ADDR_W each: target register.
REQ-008 SHALL have ports jtag_wdata / av_wdata, in, 32 each: write data.
REQ-009 SHALL have ports jtag_ack / av_ack, out, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports jtag_rdata / av_rdata, out, 32 each: read data, valid with ack.
REQ-011 SHALL have ports jtag_err / av_err, out, 1 each: abort flag, valid with ack.
REQ-012 SHALL have ports oci_read / oci_write, out, 1 each: OCI strobes; oci_addr, out, ADDR_W; oci_wdata, out, 32.
REQ-013 SHALL have ports oci_rdata, in, 32, and oci_waitrequest, in, 1: OCI read data and stall.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DONE, all outputs registered.
REQ-015 In IDLE with any request active, SHALL latch winner's wr/addr/wdata, assert exactly one OCI strobe next cycle, enter ISSUE.
REQ-016 Arbitration SHALL be round-robin: both requesting -> grant the side not granted last; single requester granted immediately.
REQ-017 In ISSUE, SHALL hold strobe, oci_addr, oci_wdata stable while oci_waitrequest=1.
REQ-018 In ISSUE with oci_waitrequest=0, SHALL drop strobe next cycle, capture oci_rdata (reads) and enter DONE.
REQ-019 In DONE, SHALL pulse granted side's ack for one cycle with err=0, rdata held until next ack to that side, then return to IDLE.
REQ-020 Minimum latency SHALL be: req sampled cycle N, strobe cycle N+1, ack cycle N+3 when waitrequest=0 at N+1.
REQ-021 A request still asserted in the cycle after its ack SHALL be treated as a new request.
REQ-022 Losing requester SHALL be served on the next IDLE without being dropped; non-granted ack/rdata/err SHALL stay unchanged.
REQ-023 oci_read and oci_write SHALL never be asserted together; strobes SHALL be 0 in IDLE and DONE.

Reset
REQ-024 Reset SHALL force IDLE; all strobes, acks, errs 0; rdata, oci_addr, oci_wdata 0; last-grant = Avalon so JTAG wins first tie.
REQ-025 Reset mid-transaction SHALL abort immediately with no ack issued.

Configuration
REQ-026 With DEBUG_ARB_TIMEOUT_EN defined, a 10-bit counter SHALL count ISSUE cycles with waitrequest=1; reaching TIMEOUT SHALL drop strobe, enter DONE, ack with err=1 and rdata=0.
REQ-027 Without DEBUG_ARB_TIMEOUT_EN, no counter SHALL exist, err outputs SHALL be tied 0, ISSUE waits indefinitely.

Verification
REQ-028 JTAG read addr 0x10, waitrequest=0, oci_rdata=0xCAFEF00D -> oci_read at N+1, jtag_ack at N+3, jtag_rdata=0xCAFEF00D, err=0.
REQ-029 Both requesters assert same cycle after reset -> JTAG granted first, Avalon second, av_ack exactly once.
REQ-030 Avalon write 0x12345678 to 0x04, waitrequest=1 for 5 cycles -> oci_write, addr, wdata stable 6 cycles, av_ack one cycle after release.
REQ-031 DEBUG_ARB_TIMEOUT_EN, TIMEOUT=8, waitrequest stuck 1 -> strobe drops after 8 stall cycles, ack with err=1, rdata=0.
REQ-032 reset_n low during ISSUE -> strobes 0 asynchronously, no ack; post-reset JTAG request completes normally.
REQ-033 Both requesters hold req continuously for 6 transactions -> grants alternate J,A,J,A,J,A, strobes never overlap.
